lmring_rtn: RTL and testbench

- Terminating stage of the LMM ring: consumes the record stream leaving the last row's lmring_br queue (lmring_bout/nemp/ful) and returns it to the AXI side.
- Read records become read-data beats; write records become write acknowledges.
- Tracks outstanding ring transactions announced by the injector, and provides a drain handshake so the AXI front end can quiesce the ring before reconfiguration.

---
 rtl/lmring_rtn.sv | 204 ++++++++++++++++++++
 tb/tb_lmring_rtn.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmring_rtn.sv
// lmring_rtn -- terminating stage of the LMM ring.
//
// Drains the record stream leaving the last row's lmring_br queue. Read
// records become read-data beats (rd_*), write records become write
// acknowledges (wa_*). It counts ring transactions announced by the
// injector (iss_*) and offers a drain handshake so the AXI front end can
// quiesce the ring before reconfiguration.
//
// Ports
//   ACLK, RSTN                 clock, async active-low reset
//   lmring_bin_nemp/_ful       upstream record valid / backpressure (comb)
//   bin_rw/ty/sq/av/d          record fields (ty is not used here)
//   iss_val/iss_rdy            injector announces one new transaction
//   rd_val/data/sq/err, rd_rdy read beat stream (2-deep queue)
//   wa_val/sq/err, wa_rdy      write ack stream (2-deep queue)
//   drain_req/drain_done       quiesce handshake
//   unexp                      sticky: completion arrived with count 0
//   err_cnt                    unserved-record count
//
// Build option: define LMRTN_ERRCNT_EN to get a saturating 16-bit count of
// accepted records with bin_av==0 on err_cnt; otherwise err_cnt is 0 and
// no counter flops are built.
//
// state    | meaning
// ST_RUN   | normal operation, issues accepted
// ST_DRAIN | drain requested, issues blocked, waiting for ring empty
// ST_DONE  | ring empty, upstream blocked, drain_done high

module lmring_rtn #(
   parameter int DATA_BITS = 256,
   parameter int SQ_BITS   = 16,
   parameter int OUT_BITS  = 8
) (
   input  logic                 ACLK,
   input  logic                 RSTN,
   input  logic                 lmring_bin_nemp,
   output logic                 lmring_bin_ful,
   input  logic                 bin_rw,
   input  logic [2:0]           bin_ty,
   input  logic [SQ_BITS-1:0]   bin_sq,
   input  logic                 bin_av,
   input  logic [DATA_BITS-1:0] bin_d,
   input  logic                 iss_val,
   output logic                 iss_rdy,
   output logic                 rd_val,
   output logic [DATA_BITS-1:0] rd_data,
   output logic [SQ_BITS-1:0]   rd_sq,
   output logic                 rd_err,
   input  logic                 rd_rdy,
   output logic                 wa_val,
   output logic [SQ_BITS-1:0]   wa_sq,
   output logic                 wa_err,
   input  logic                 wa_rdy,
   input  logic                 drain_req,
   output logic                 drain_done,
   output logic                 unexp,
   output logic [15:0]          err_cnt
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [OUT_BITS-1:0] CNT_ONE = {{(OUT_BITS-1){1'b0}}, 1'b1};

   logic [1:0]          state_q, state_d;
   logic [OUT_BITS-1:0] cnt_q, cnt_d;
   logic                unexp_q, unexp_d;

   logic [DATA_BITS-1:0] rdq_data_q [2];
   logic [SQ_BITS-1:0]   rdq_sq_q   [2];
   logic [1:0]           rdq_err_q;
   logic                 rdq_wp_q, rdq_wp_d, rdq_rp_q, rdq_rp_d;
   logic [1:0]           rdq_cnt_q, rdq_cnt_d;

   logic [SQ_BITS-1:0]   waq_sq_q   [2];
   logic [1:0]           waq_err_q;
   logic                 waq_wp_q, waq_wp_d, waq_rp_q, waq_rp_d;
   logic [1:0]           waq_cnt_q, waq_cnt_d;

   logic accept, push_rd, push_wa, pop_rd, pop_wa, iss_acc;
   logic unused_ok;

   assign unused_ok = ^bin_ty;

   // Full is taken from the occupancy before any pop this cycle, which keeps
   // rd_rdy/wa_rdy out of the backpressure path.
   assign lmring_bin_ful = (bin_rw ? (waq_cnt_q == 2'd2) : (rdq_cnt_q == 2'd2))
                           || (state_q == ST_DONE);
   assign accept  = lmring_bin_nemp && !lmring_bin_ful;
   assign push_rd = accept && !bin_rw;
   assign push_wa = accept && bin_rw;

   assign rd_val  = (rdq_cnt_q != 2'd0);
   assign wa_val  = (waq_cnt_q != 2'd0);
   assign pop_rd  = rd_val && rd_rdy;
   assign pop_wa  = wa_val && wa_rdy;

   // Payload is gated so that an empty queue presents zeros.
   assign rd_data = rd_val ? rdq_data_q[rdq_rp_q] : '0;
   assign rd_sq   = rd_val ? rdq_sq_q[rdq_rp_q]   : '0;
   assign rd_err  = rd_val && rdq_err_q[rdq_rp_q];
   assign wa_sq   = wa_val ? waq_sq_q[waq_rp_q]   : '0;
   assign wa_err  = wa_val && waq_err_q[waq_rp_q];

   assign iss_rdy    = (state_q == ST_RUN) && (cnt_q != '1);
   assign iss_acc    = iss_val && iss_rdy;
   assign drain_done = (state_q == ST_DONE);
   assign unexp      = unexp_q;

   function automatic logic [1:0] occ_next(input logic [1:0] occ,
                                           input logic push, input logic pop);
      case ({push, pop})
         2'b10:   return occ + 2'd1;
         2'b01:   return occ - 2'd1;
         default: return occ;
      endcase
   endfunction

   always_comb begin
      rdq_cnt_d = occ_next(rdq_cnt_q, push_rd, pop_rd);
      rdq_wp_d  = rdq_wp_q ^ push_rd;
      rdq_rp_d  = rdq_rp_q ^ pop_rd;
      waq_cnt_d = occ_next(waq_cnt_q, push_wa, pop_wa);
      waq_wp_d  = waq_wp_q ^ push_wa;
      waq_rp_d  = waq_rp_q ^ pop_wa;

      cnt_d   = cnt_q;
      unexp_d = unexp_q;
      if (iss_acc && !accept) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (accept && !iss_acc) begin
         // A completion nobody announced: hold at zero and flag it.
         if (cnt_q == '0) unexp_d = 1'b1;
         else             cnt_d   = cnt_q - CNT_ONE;
      end

      state_d = state_q;
      case (state_q)
         ST_RUN:   if (drain_req) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (!drain_req)
               state_d = ST_RUN;
            else if ((cnt_q == '0) && (rdq_cnt_q == 2'd0) && (waq_cnt_q == 2'd0))
               state_d = ST_DONE;
         end
         ST_DONE:  if (!drain_req) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         unexp_q   <= 1'b0;
         rdq_cnt_q <= 2'd0;
         rdq_wp_q  <= 1'b0;
         rdq_rp_q  <= 1'b0;
         rdq_err_q <= 2'b00;
         waq_cnt_q <= 2'd0;
         waq_wp_q  <= 1'b0;
         waq_rp_q  <= 1'b0;
         waq_err_q <= 2'b00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         unexp_q   <= unexp_d;
         rdq_cnt_q <= rdq_cnt_d;
         rdq_wp_q  <= rdq_wp_d;
         rdq_rp_q  <= rdq_rp_d;
         waq_cnt_q <= waq_cnt_d;
         waq_wp_q  <= waq_wp_d;
         waq_rp_q  <= waq_rp_d;
         if (push_rd) rdq_err_q[rdq_wp_q] <= !bin_av;
         if (push_wa) waq_err_q[waq_wp_q] <= !bin_av;
      end
   end

   // Wide payload storage needs no reset: it is only visible while the
   // matching occupancy count is non-zero.
   always_ff @(posedge ACLK) begin
      if (push_rd) begin
         rdq_data_q[rdq_wp_q] <= bin_d;
         rdq_sq_q[rdq_wp_q]   <= bin_sq;
      end
      if (push_wa) waq_sq_q[waq_wp_q] <= bin_sq;
   end

`ifdef LMRTN_ERRCNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN)
         err_cnt_q <= 16'h0000;
      else if (accept && !bin_av && (err_cnt_q != 16'hFFFF))
         err_cnt_q <= err_cnt_q + 16'd1;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lmring_rtn.sv
// Testbench for lmring_rtn: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.

module tb_lmring_rtn;

   logic         ACLK = 1'b0;
   logic         RSTN = 1'b0;
   logic         lmring_bin_nemp = 1'b0;
   logic         lmring_bin_ful;
   logic         bin_rw = 1'b0;
   logic [2:0]   bin_ty = 3'd4;
   logic [15:0]  bin_sq = '0;
   logic         bin_av = 1'b0;
   logic [255:0] bin_d = '0;
   logic         iss_val = 1'b0;
   logic         iss_rdy;
   logic         rd_val;
   logic [255:0] rd_data;
   logic [15:0]  rd_sq;
   logic         rd_err;
   logic         rd_rdy = 1'b0;
   logic         wa_val;
   logic [15:0]  wa_sq;
   logic         wa_err;
   logic         wa_rdy = 1'b0;
   logic         drain_req = 1'b0;
   logic         drain_done;
   logic         unexp;
   logic [15:0]  err_cnt;

   lmring_rtn #(.DATA_BITS(256), .SQ_BITS(16), .OUT_BITS(8)) dut (
      .ACLK(ACLK), .RSTN(RSTN),
      .lmring_bin_nemp(lmring_bin_nemp), .lmring_bin_ful(lmring_bin_ful),
      .bin_rw(bin_rw), .bin_ty(bin_ty), .bin_sq(bin_sq), .bin_av(bin_av), .bin_d(bin_d),
      .iss_val(iss_val), .iss_rdy(iss_rdy),
      .rd_val(rd_val), .rd_data(rd_data), .rd_sq(rd_sq), .rd_err(rd_err), .rd_rdy(rd_rdy),
      .wa_val(wa_val), .wa_sq(wa_sq), .wa_err(wa_err), .wa_rdy(wa_rdy),
      .drain_req(drain_req), .drain_done(drain_done), .unexp(unexp), .err_cnt(err_cnt)
   );

   always #5 ACLK = ~ACLK;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   typedef struct { logic [255:0] d; logic [15:0] sq; logic err; } rd_rec_t;
   typedef struct { logic [15:0] sq; logic err; } wa_rec_t;
   typedef enum { M_RUN, M_DRAIN, M_DONE } mst_t;

   rd_rec_t m_rdq[$];
   wa_rec_t m_waq[$];
   int      m_cnt = 0;
   bit      m_unexp = 0;
   int      m_errcnt = 0;
   mst_t    m_st = M_RUN;

   function automatic bit m_ful();
      return (bin_rw ? (m_waq.size() == 2) : (m_rdq.size() == 2)) || (m_st == M_DONE);
   endfunction

   function automatic bit m_irdy();
      return (m_st == M_RUN) && (m_cnt < 255);
   endfunction

   function automatic logic [255:0] dat_of(input logic [15:0] s);
      if (s == 16'h0012) return {32{8'hA5}};
      return {16{s ^ 16'h5A5A}};
   endfunction

   task automatic model_reset();
      m_rdq.delete();
      m_waq.delete();
      m_cnt = 0;
      m_unexp = 0;
      m_errcnt = 0;
      m_st = M_RUN;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   task automatic check_model();
      bit e_rv, e_wv, ok;
      e_rv = m_rdq.size() > 0;
      e_wv = m_waq.size() > 0;
      ok = (rd_val === e_rv) && (wa_val === e_wv) &&
           (lmring_bin_ful === m_ful()) && (iss_rdy === m_irdy()) &&
           (unexp === m_unexp) && (drain_done === (m_st == M_DONE));
      if (e_rv) ok = ok && (rd_data === m_rdq[0].d) && (rd_sq === m_rdq[0].sq) && (rd_err === m_rdq[0].err);
      if (e_wv) ok = ok && (wa_sq === m_waq[0].sq) && (wa_err === m_waq[0].err);
`ifdef LMRTN_ERRCNT_EN
      ok = ok && (err_cnt === 16'(m_errcnt));
`else
      ok = ok && (err_cnt === 16'h0000);
`endif
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL model @%0t: got rv=%0b rsq=%h re=%0b rd=%h wv=%0b wsq=%h we=%0b ful=%0b irdy=%0b ux=%0b dd=%0b ec=%0d | required rv=%0b rsq=%h re=%0b rd=%h wv=%0b wsq=%h we=%0b ful=%0b irdy=%0b ux=%0b dd=%0b ec=%0d",
                  $time, rd_val, rd_sq, rd_err, rd_data[31:0], wa_val, wa_sq, wa_err,
                  lmring_bin_ful, iss_rdy, unexp, drain_done, err_cnt,
                  e_rv, e_rv ? m_rdq[0].sq : 16'h0, e_rv ? m_rdq[0].err : 1'b0,
                  e_rv ? m_rdq[0].d[31:0] : 32'h0, e_wv, e_wv ? m_waq[0].sq : 16'h0,
                  e_wv ? m_waq[0].err : 1'b0, m_ful(), m_irdy(), m_unexp, m_st == M_DONE, m_errcnt);
      end
   endtask

   // Called at a falling edge with inputs already driven; returns at the next
   // falling edge with the model advanced across the rising edge.
   task automatic cycle();
      bit acc, inc, prd, pwa;
      mst_t nst;
      rd_rec_t r;
      wa_rec_t w;
      #1;
      check_model();
      acc = lmring_bin_nemp && !m_ful();
      inc = iss_val && m_irdy();
      prd = (m_rdq.size() > 0) && rd_rdy;
      pwa = (m_waq.size() > 0) && wa_rdy;
      r.d = bin_d; r.sq = bin_sq; r.err = !bin_av;
      w.sq = bin_sq; w.err = !bin_av;
      nst = m_st;
      case (m_st)
         M_RUN:   if (drain_req) nst = M_DRAIN;
         M_DRAIN: if (!drain_req) nst = M_RUN;
                  else if (m_cnt == 0 && m_rdq.size() == 0 && m_waq.size() == 0) nst = M_DONE;
         M_DONE:  if (!drain_req) nst = M_RUN;
         default: nst = M_RUN;
      endcase
      @(posedge ACLK);
      if (prd) void'(m_rdq.pop_front());
      if (pwa) void'(m_waq.pop_front());
      if (acc && !bin_rw) m_rdq.push_back(r);
      if (acc && bin_rw)  m_waq.push_back(w);
      if (acc && !r.err ? 1'b0 : acc) if (m_errcnt < 65535) m_errcnt++;
      if (inc && !acc) m_cnt++;
      else if (acc && !inc) begin
         if (m_cnt == 0) m_unexp = 1;
         else m_cnt--;
      end
      m_st = nst;
      @(negedge ACLK);
   endtask

   task automatic drive(input bit nemp, input bit rw, input bit av, input logic [15:0] sq,
                        input bit iss, input bit rrdy, input bit wrdy, input bit drn);
      lmring_bin_nemp = nemp; bin_rw = rw; bin_av = av; bin_sq = sq; bin_d = dat_of(sq);
      iss_val = iss; rd_rdy = rrdy; wa_rdy = wrdy; drain_req = drn;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit nemp, rw, av; bit [15:0] sq; bit iss, rrdy, wrdy, drn;
      bit e_rv; bit [15:0] e_rsq; bit e_rerr;
      bit e_wv; bit [15:0] e_wsq; bit e_werr;
      bit e_ful, e_irdy, e_unexp, e_done;
   } vec_t;
   vec_t vt[$];

   task automatic add(input bit nemp, input bit rw, input bit av, input bit [15:0] sq,
                      input bit iss, input bit rrdy, input bit wrdy, input bit drn,
                      input bit rv, input bit [15:0] rsq, input bit rerr,
                      input bit wv, input bit [15:0] wsq, input bit werr,
                      input bit ful, input bit irdy, input bit ux, input bit done);
      vec_t v;
      v.nemp = nemp; v.rw = rw; v.av = av; v.sq = sq; v.iss = iss; v.rrdy = rrdy;
      v.wrdy = wrdy; v.drn = drn; v.e_rv = rv; v.e_rsq = rsq; v.e_rerr = rerr;
      v.e_wv = wv; v.e_wsq = wsq; v.e_werr = werr; v.e_ful = ful; v.e_irdy = irdy;
      v.e_unexp = ux; v.e_done = done;
      vt.push_back(v);
   endtask

   task automatic check_vec(input int i);
      vec_t v;
      bit ok;
      v = vt[i];
      ok = (rd_val === v.e_rv) && (wa_val === v.e_wv) && (lmring_bin_ful === v.e_ful) &&
           (iss_rdy === v.e_irdy) && (unexp === v.e_unexp) && (drain_done === v.e_done);
      if (v.e_rv) ok = ok && (rd_sq === v.e_rsq) && (rd_err === v.e_rerr);
      if (v.e_wv) ok = ok && (wa_sq === v.e_wsq) && (wa_err === v.e_werr);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL vec[%0d]: got rv=%0b rsq=%h re=%0b wv=%0b wsq=%h we=%0b ful=%0b irdy=%0b ux=%0b dd=%0b | required rv=%0b rsq=%h re=%0b wv=%0b wsq=%h we=%0b ful=%0b irdy=%0b ux=%0b dd=%0b",
                  i, rd_val, rd_sq, rd_err, wa_val, wa_sq, wa_err, lmring_bin_ful, iss_rdy,
                  unexp, drain_done, v.e_rv, v.e_rsq, v.e_rerr, v.e_wv, v.e_wsq, v.e_werr,
                  v.e_ful, v.e_irdy, v.e_unexp, v.e_done);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_rd_val"}, 64'(rd_val), 64'd0);
      chk({name, "_rd_data"}, 64'(rd_data[63:0]), 64'd0);
      chk({name, "_wa_val"}, 64'(wa_val), 64'd0);
      chk({name, "_ful"}, 64'(lmring_bin_ful), 64'd0);
      chk({name, "_iss_rdy"}, 64'(iss_rdy), 64'd1);
      chk({name, "_unexp"}, 64'(unexp), 64'd0);
      chk({name, "_done"}, 64'(drain_done), 64'd0);
      chk({name, "_err_cnt"}, 64'(err_cnt), 64'd0);
   endtask

   initial begin
      //   nemp rw av sq     iss rr wr dr | rv rsq   re wv wsq  we ful irdy ux dd
      add(0, 0, 1, 16'h00, 1, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 0, 0); // issue
      add(1, 0, 1, 16'h12, 0, 1, 1, 0,   1, 16'h12, 0, 0, 16'h0, 0, 0, 1, 0, 0); // read served
      add(0, 0, 1, 16'h00, 0, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 0, 0);
      add(0, 0, 1, 16'h00, 1, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 0, 0);
      add(1, 1, 0, 16'h07, 0, 1, 1, 0,   0, 16'h00, 0, 1, 16'h7, 1, 0, 1, 0, 0); // write unserved
      add(0, 0, 1, 16'h00, 0, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 0, 0);
      add(0, 0, 1, 16'h00, 1, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 0, 0); // cnt 1
      add(0, 0, 1, 16'h00, 1, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 0, 0); // cnt 2
      add(0, 0, 1, 16'h00, 1, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 0, 0); // cnt 3
      add(1, 0, 1, 16'h03, 1, 1, 1, 0,   1, 16'h03, 0, 0, 16'h0, 0, 0, 1, 0, 0); // issue+record: cnt 3
      add(0, 0, 1, 16'h00, 0, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 0, 0);
      add(1, 0, 1, 16'h21, 0, 1, 1, 0,   1, 16'h21, 0, 0, 16'h0, 0, 0, 1, 0, 0); // cnt 2
      add(1, 0, 1, 16'h22, 0, 1, 1, 0,   1, 16'h22, 0, 0, 16'h0, 0, 0, 1, 0, 0); // cnt 1
      add(1, 0, 1, 16'h23, 0, 1, 1, 0,   1, 16'h23, 0, 0, 16'h0, 0, 0, 1, 0, 0); // cnt 0
      add(1, 0, 1, 16'h24, 0, 1, 1, 0,   1, 16'h24, 0, 0, 16'h0, 0, 0, 1, 1, 0); // unexpected
      add(0, 0, 1, 16'h00, 0, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 1, 0);
      add(1, 0, 1, 16'h01, 0, 0, 1, 0,   1, 16'h01, 0, 0, 16'h0, 0, 0, 1, 1, 0); // backpressure
      add(1, 0, 1, 16'h02, 0, 0, 1, 0,   1, 16'h01, 0, 0, 16'h0, 0, 1, 1, 1, 0);
      add(1, 0, 1, 16'h03, 0, 0, 1, 0,   1, 16'h01, 0, 0, 16'h0, 0, 1, 1, 1, 0);
      add(1, 0, 1, 16'h03, 0, 1, 1, 0,   1, 16'h02, 0, 0, 16'h0, 0, 0, 1, 1, 0);
      add(1, 0, 1, 16'h03, 0, 1, 1, 0,   1, 16'h03, 0, 0, 16'h0, 0, 0, 1, 1, 0);
      add(0, 0, 1, 16'h00, 0, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 1, 0);
      add(0, 0, 1, 16'h00, 1, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 1, 0); // cnt 1
      add(0, 0, 1, 16'h00, 1, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 1, 0); // cnt 2
      add(0, 0, 1, 16'h00, 0, 1, 1, 1,   0, 16'h00, 0, 0, 16'h0, 0, 0, 0, 1, 0); // drain
      add(1, 0, 1, 16'h31, 0, 0, 0, 1,   1, 16'h31, 0, 0, 16'h0, 0, 0, 0, 1, 0);
      add(1, 1, 1, 16'h32, 0, 0, 0, 1,   1, 16'h31, 0, 1, 16'h32, 0, 0, 0, 1, 0);
      add(0, 0, 1, 16'h00, 0, 1, 0, 1,   0, 16'h00, 0, 1, 16'h32, 0, 0, 0, 1, 0);
      add(0, 0, 1, 16'h00, 0, 1, 1, 1,   0, 16'h00, 0, 0, 16'h0, 0, 0, 0, 1, 0); // 2nd popped
      add(0, 0, 1, 16'h00, 0, 1, 1, 1,   0, 16'h00, 0, 0, 16'h0, 0, 1, 0, 1, 1); // done
      add(1, 0, 1, 16'h40, 0, 1, 1, 1,   0, 16'h00, 0, 0, 16'h0, 0, 1, 0, 1, 1); // blocked
      add(0, 0, 1, 16'h00, 0, 1, 1, 0,   0, 16'h00, 0, 0, 16'h0, 0, 0, 1, 1, 0); // back to run

      // reset state
      repeat (2) @(negedge ACLK);
      #1;
      check_reset_outputs("reset");
      @(negedge ACLK);
      RSTN = 1'b1;

      // table
      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].nemp, vt[i].rw, vt[i].av, vt[i].sq, vt[i].iss, vt[i].rrdy, vt[i].wrdy, vt[i].drn);
         cycle();
         check_vec(i);
      end
      chk("rd_data_A5", rd_data[63:0], 64'h0);

      // counter saturation: 255 issues with no records
      drive(0, 0, 1, 16'h0, 1, 1, 1, 0);
      for (int i = 0; i < 255; i++) cycle();
      chk("iss_rdy_sat", 64'(iss_rdy), 64'd0);
      cycle();
      chk("iss_rdy_sat_hold", 64'(iss_rdy), 64'd0);
      drive(1, 1, 1, 16'h55, 0, 1, 1, 0);
      cycle();
      chk("iss_rdy_after_dec", 64'(iss_rdy), 64'd1);
      drive(0, 0, 1, 16'h0, 0, 1, 1, 0);
      cycle();

      // asynchronous reset with two read entries queued
      drive(1, 0, 1, 16'h61, 0, 0, 1, 0);
      cycle();
      drive(1, 0, 1, 16'h62, 0, 0, 1, 0);
      cycle();
      chk("pre_reset_full", 64'(lmring_bin_ful), 64'd1);
      drive(0, 0, 1, 16'h0, 0, 0, 0, 0);
      #3;
      RSTN = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      @(negedge ACLK);
      @(negedge ACLK);
      RSTN = 1'b1;
      drive(0, 0, 1, 16'h0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) cycle();
      chk("no_stale_beat", 64'(rd_val), 64'd0);
      drive(1, 0, 1, 16'h70, 0, 1, 1, 0);
      cycle();
      chk("cnt_zero_after_reset", 64'(unexp), 64'd1);

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         lmring_bin_nemp = ($urandom_range(0, 1) == 1);
         bin_rw  = ($urandom_range(0, 1) == 1);
         bin_av  = ($urandom_range(0, 3) != 0);
         bin_ty  = 3'($urandom_range(0, 4));
         bin_sq  = 16'($urandom());
         bin_d   = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
         iss_val = ($urandom_range(0, 1) == 1);
         rd_rdy  = ($urandom_range(0, 9) < 7);
         wa_rdy  = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
